// File: rtl/ps2_keypad_multidigit_pkg.sv
// Shared scan-code constants, receiver state encodings and display helpers
// for the PS/2 multi-digit keypad front end.
package ps2_keypad_multidigit_pkg;

  typedef logic [7:0] scan_t;

  localparam scan_t SC_EXT  = 8'hE0;
  localparam scan_t SC_BRK  = 8'hF0;
  localparam scan_t SC_BKSP = 8'h66;
  localparam scan_t SC_ESC  = 8'h76;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Returns {is_digit, value}; top-row and keypad codes map to the same digit.
  function automatic logic [4:0] scan_to_digit(input scan_t sc);
    case (sc)
      8'h45, 8'h70: scan_to_digit = {1'b1, 4'd0};
      8'h16, 8'h69: scan_to_digit = {1'b1, 4'd1};
      8'h1E, 8'h72: scan_to_digit = {1'b1, 4'd2};
      8'h26, 8'h7A: scan_to_digit = {1'b1, 4'd3};
      8'h25, 8'h6B: scan_to_digit = {1'b1, 4'd4};
      8'h2E, 8'h73: scan_to_digit = {1'b1, 4'd5};
      8'h36, 8'h74: scan_to_digit = {1'b1, 4'd6};
      8'h3D, 8'h6C: scan_to_digit = {1'b1, 4'd7};
      8'h3E, 8'h75: scan_to_digit = {1'b1, 4'd8};
      8'h46, 8'h7D: scan_to_digit = {1'b1, 4'd9};
      default:      scan_to_digit = 5'd0;
    endcase
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything above 9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keypad_multidigit_if.sv
// PS/2 pin pair plus the framed-byte result; the keyboard side is master.
interface ps2_keypad_multidigit_if;
  import ps2_keypad_multidigit_pkg::*;

  logic  keyb_clk;
  logic  keyb_data;
  scan_t scan_code;
  logic  code_valid;
  logic  frame_err;

  modport master (output keyb_clk, keyb_data, input scan_code, code_valid, frame_err);
  modport slave  (input keyb_clk, keyb_data, output scan_code, code_valid, frame_err);
endinterface

// File: rtl/ps2_keypad_multidigit_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// start/parity/stop checks and an inter-bit timeout.
module ps2_keypad_multidigit_rx_frame
  import ps2_keypad_multidigit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  keyb_clk,
  input  logic  keyb_data,
  output scan_t scan_code,
  output logic  code_valid,
  output logic  frame_err
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   r_clk_prev;
  logic [1:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [TMO_W-1:0]       r_tmo;
  logic [7:0]             r_shift;
  logic                   r_parity;
  scan_t                  r_scan_code;
  logic                   r_code_valid, r_frame_err;
  logic                   w_clk_s, w_data_s, w_fall, w_par_ok;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;
  assign w_par_ok = ^{r_shift, r_parity};

  // Idle PS/2 lines are high, so the chains reset high to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], keyb_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], keyb_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fall && r_state == ST_DATA)   r_shift  <= {w_data_s, r_shift[7:1]};
    if (w_fall && r_state == ST_PARITY) r_parity <= w_data_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_tmo        <= '0;
      r_scan_code  <= 8'h00;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_tmo <= '0;
        if (w_fall) begin
          if (!w_data_s) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= 3'd0;
          end else begin
            r_frame_err <= 1'b1;
          end
        end
      end else if (w_fall) begin
        r_tmo <= '0;
        case (r_state)
          ST_DATA: begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: r_state <= ST_STOP;
          default: begin
            if (w_data_s && w_par_ok) begin
              r_code_valid <= 1'b1;
              r_scan_code  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
        r_tmo       <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign scan_code  = r_scan_code;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keypad_multidigit.sv
// PS/2 keypad front end: make/break/extended tracking, a decimal entry
// register and a multiplexed active-low 7-segment display.
module ps2_keypad_multidigit
  import ps2_keypad_multidigit_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int REFRESH_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_keypad_multidigit_if.slave  bus,
  output logic [3:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RC_W  = $clog2(REFRESH_CYCLES + 1);

  scan_t             w_scan_code;
  logic              w_code_valid, w_frame_err;
  logic [4:0]        w_dig;
  logic [3:0]        w_nibble;
  logic              r_ext, r_brk;
  logic [3:0]        r_count;
  logic [DW-1:0]     r_digits;
  logic [RC_W-1:0]   r_ref_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [6:0]        r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  ps2_keypad_multidigit_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .keyb_clk  (bus.keyb_clk),
    .keyb_data (bus.keyb_data),
    .scan_code (w_scan_code),
    .code_valid(w_code_valid),
    .frame_err (w_frame_err)
  );

  assign bus.scan_code  = w_scan_code;
  assign bus.code_valid = w_code_valid;
  assign bus.frame_err  = w_frame_err;

  assign w_dig = scan_to_digit(w_scan_code);

  // Prefix bytes only arm flags; the next non-prefix byte consumes and clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_count  <= 4'd0;
      r_digits <= '0;
    end else if (w_code_valid) begin
      if (w_scan_code == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_scan_code == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_brk && !r_ext) begin
          if (w_dig[4]) begin
            r_digits <= (r_digits << 4) | DW'(w_dig[3:0]);
            if (r_count != 4'(NUM_DIGITS)) r_count <= r_count + 4'd1;
          end else if (w_scan_code == SC_BKSP && r_count != 4'd0) begin
            r_digits <= r_digits >> 4;
            r_count  <= r_count - 4'd1;
          end else if (w_scan_code == SC_ESC) begin
            r_digits <= '0;
            r_count  <= 4'd0;
          end
        end
      end
    end
  end

  assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
      r_seg     <= 7'h7F;
      r_an      <= '1;
    end else begin
      if (r_ref_cnt == RC_W'(REFRESH_CYCLES - 1)) begin
        r_ref_cnt <= '0;
        r_idx     <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= ({{(4 - IDX_W){1'b0}}, r_idx} < r_count) ? seg7(w_nibble) : 7'h7F;
    end
  end

  assign digit_count = r_count;
  assign digits_bcd  = r_digits;
  assign seg         = r_seg;
  assign an          = r_an;

endmodule

// File: tb/tb_ps2_keypad_multidigit.sv
// Bench for ps2_keypad_multidigit: bit-banged PS/2 frames, a scan-code
// scoreboard and per-scenario checks of the entry register and display.
module tb_ps2_keypad_multidigit;
  localparam int NUM_DIGITS     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int REFRESH_CYCLES = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int HALF           = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  digit_count;
  logic [15:0] digits_bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int   total = 0;
  int   bad   = 0;
  int   err_seen = 0;
  logic prev_cv = 1'b0;
  logic [7:0] exp_q[$];

  ps2_keypad_multidigit_if bus();

  ps2_keypad_multidigit #(
    .NUM_DIGITS    (NUM_DIGITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .digit_count(digit_count),
    .digits_bcd (digits_bcd),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  // Scoreboard: every code_valid pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (bus.code_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: scan_code=%h with nothing expected", bus.scan_code);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.scan_code !== e) begin
          bad++;
          $display("FAIL sb_scan_code: got %h expected %h", bus.scan_code, e);
        end
      end
      if (prev_cv) begin
        bad++;
        $display("FAIL cv_pulse_width: code_valid high two cycles");
      end
    end
    if (bus.frame_err) err_seen++;
    prev_cv = bus.code_valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits,
                            input logic expect_ok);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    if (expect_ok) exp_q.push_back(b);
    for (int i = 0; i < nbits; i++) begin
      bus.keyb_data = f[i];
      repeat (HALF) @(negedge clk);
      bus.keyb_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.keyb_clk = 1'b1;
    end
    bus.keyb_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_code(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b1);
  endtask

  task automatic wait_an(input int idx, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << idx);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (an === want) ok = 1'b1;
    end
  endtask

  task automatic check_seg_at(input int idx, input logic [6:0] exp_seg, input string name);
    bit ok;
    wait_an(idx, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: an never selected digit %0d (an=%b)", name, idx, an);
    end else if (seg !== exp_seg) begin
      bad++;
      $display("FAIL %s: seg=%h expected %h", name, seg, exp_seg);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (bus.scan_code !== 8'h00 || bus.code_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_rx: scan=%h cv=%b err=%b expected 00/0/0", tag,
               bus.scan_code, bus.code_valid, bus.frame_err);
    end
    total++;
    if (digit_count !== 4'd0 || digits_bcd !== 16'h0000) begin
      bad++;
      $display("FAIL %s_entry: count=%0d digits=%h expected 0/0000", tag, digit_count, digits_bcd);
    end
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++;
      $display("FAIL %s_display: an=%b seg=%h expected 1111/7f", tag, an, seg);
    end
  endtask

  task automatic check_entry(input logic [3:0] exp_cnt, input logic [15:0] exp_dig,
                             input string name);
    total++;
    if (digit_count !== exp_cnt || digits_bcd !== exp_dig) begin
      bad++;
      $display("FAIL %s: count=%0d digits=%h expected %0d/%h", name,
               digit_count, digits_bcd, exp_cnt, exp_dig);
    end
  endtask

  task automatic test_reset();
    bus.keyb_clk  = 1'b1;
    bus.keyb_data = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_first_digit();
    send_code(8'h16);
    check_entry(4'd1, 16'h0001, "first_digit");
    check_seg_at(0, 7'h79, "first_digit_seg");
    check_seg_at(1, 7'h7F, "first_digit_blank");
  endtask

  task automatic test_fill();
    send_code(8'h1E);
    send_code(8'h26);
    send_code(8'h25);
    send_code(8'h2E);
    check_entry(4'd4, 16'h2345, "fill_overflow");
    check_seg_at(3, 7'h24, "fill_seg_msd");
  endtask

  task automatic test_break();
    send_code(8'hF0);
    send_code(8'h16);
    check_entry(4'd4, 16'h2345, "break_ignored");
    send_code(8'hE0);
    send_code(8'h16);
    check_entry(4'd4, 16'h2345, "ext_ignored");
    send_code(8'h16);
    check_entry(4'd4, 16'h3451, "make_after_break");
  endtask

  task automatic test_parity_err();
    int e0;
    e0 = err_seen;
    send_frame(8'h1E, 1'b1, 11, 1'b0);
    total++;
    if (err_seen !== e0 + 1) begin
      bad++;
      $display("FAIL parity_err: frame_err pulses=%0d expected %0d", err_seen - e0, 1);
    end
    total++;
    if (bus.scan_code !== 8'h16) begin
      bad++;
      $display("FAIL parity_hold: scan_code=%h expected 16", bus.scan_code);
    end
    check_entry(4'd4, 16'h3451, "parity_no_entry");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    send_frame(8'h16, 1'b0, 4, 1'b0);
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    total++;
    if (err_seen !== e0 + 1) begin
      bad++;
      $display("FAIL timeout_err: frame_err pulses=%0d expected %0d", err_seen - e0, 1);
    end
    send_code(8'h45);
    check_entry(4'd4, 16'h4510, "after_timeout");
  endtask

  task automatic test_backspace_escape();
    send_code(8'h76);
    check_entry(4'd0, 16'h0000, "escape_clear");
    send_code(8'h3D);
    send_code(8'h3E);
    send_code(8'h66);
    check_entry(4'd1, 16'h0007, "backspace");
    check_seg_at(0, 7'h78, "backspace_seg");
    send_code(8'h76);
    check_entry(4'd0, 16'h0000, "escape");
    for (int i = 0; i < NUM_DIGITS; i++) check_seg_at(i, 7'h7F, "escape_blank");
    send_code(8'h66);
    check_entry(4'd0, 16'h0000, "backspace_at_zero");
  endtask

  task automatic test_reset_mid_frame();
    send_code(8'h16);
    check_entry(4'd1, 16'h0001, "pre_reset_entry");
    send_frame(8'h16, 1'b0, 6, 1'b0);
    reset = 1'b0;
    #3;
    check_reset_values("reset_mid");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_code(8'h70);
    check_entry(4'd1, 16'h0000, "keypad_zero");
    check_seg_at(0, 7'h40, "keypad_zero_seg");
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_fill();
    test_break();
    test_parity_err();
    test_timeout();
    test_backspace_escape();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expected bytes never received", exp_q.size());
    end
    total++;
    if (err_seen != 2) begin
      bad++;
      $display("FAIL err_total: frame_err pulses=%0d expected 2", err_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keypad_multidigit.md
Name: ps2_keypad_multidigit

Overview:
Next-generation PS/2 keyboard front end. It receives PS/2 device-to-host frames with full framing checks (start, odd parity, stop, inter-bit timeout) and tracks make, break and extended prefixes. Digit keys (top row and keypad) are collected into a NUM_DIGITS-wide decimal entry register, which is shown on time-multiplexed active-low 7-segment displays. It sits between the PS/2 connector pins and the board display, replacing the single-digit keyboard display block.

Parameters:
NUM_DIGITS, 4, number of displayed decimal digits (1..8)
TIMEOUT_CYCLES, 20000, clk cycles without a PS/2 falling edge mid-frame before the frame is aborted
REFRESH_CYCLES, 1000, clk cycles each digit is shown during multiplexing
SYNC_STAGES, 2, synchroniser depth on keyb_clk and keyb_data (at least 2)

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
keyb_clk  input  1  PS/2 clock from the device (open-collector; treated as input only)
keyb_data  input  1  PS/2 data from the device
scan_code  output  8  last correctly framed byte
code_valid  output  1  one-cycle pulse per correctly framed byte
frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error
digit_count  output  4  number of digits entered (0..NUM_DIGITS)
digits_bcd  output  4*NUM_DIGITS  entered digits; digit 0 is the least significant nibble
seg  output  7  active-low segments {g,f,e,d,c,b,a}
an  output  NUM_DIGITS  active-low digit enables, one-hot

Behaviour:
- Reset (reset=0, asynchronous): scan_code=8'h00, code_valid=0, frame_err=0, digit_count=0, digits_bcd=0, an=all 1s, seg=7'h7F, FSM=IDLE, break and extended flags cleared. Reset mid-frame discards the partial frame.
- Input handling: keyb_clk and keyb_data pass through SYNC_STAGES flops. A falling edge is detected on the synchronised keyb_clk, and keyb_data is sampled on that cycle.
- Receiver FSM:
  - IDLE: on an edge, sampled data 0 goes to DATA with bit_cnt=0; sampled data 1 stays in IDLE and pulses frame_err.
  - DATA: 8 edges, shifting LSB first, then go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: on the edge, check stop=1 and odd parity over data+parity. If both pass, pulse code_valid the next cycle and update scan_code in the same cycle; otherwise pulse frame_err. Return to IDLE either way.
  - Timeout: in any non-IDLE state, a counter that reaches TIMEOUT_CYCLES with no edge pulses frame_err and returns to IDLE. The counter resets on every edge.
- Code interpretation happens on code_valid:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Any other byte is a key event. It is a make event only if brk=0. Both flags clear after any key event.
  - Extended make codes (ext=1) are ignored.
- Make-code actions; entry register updates the cycle after code_valid:
  - Digits 0-9, top row 45,16,1E,26,25,2E,36,3D,3E,46; keypad 70,69,72,7A,6B,73,74,6C,75,7D: shift digits_bcd left one nibble and insert the digit at nibble 0. digit_count saturates at NUM_DIGITS; when full, the most significant digit is dropped.
  - 66 (backspace): shift right one nibble, zero-fill the top nibble, decrement digit_count (no action at 0).
  - 76 (escape): clear digits_bcd and set digit_count=0.
  - Other codes: no effect on the entry register.
- Display:
  - A refresh counter advances the active digit index every REFRESH_CYCLES, wrapping from NUM_DIGITS-1 to 0.
  - an drives a single low bit at the active index.
  - seg shows the hex-to-7-seg of that nibble when index < digit_count; otherwise the digit is blanked (seg=7'h7F).
  - Encoding (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
- Simultaneity: code_valid and timeout cannot coincide, because an edge resets the timeout. Display refresh runs independently of reception.

Decomposition:
- Shared header ps2_defs.vh holds:
  - scan-code localparams: digits, E0, F0, 66, 76;
  - FSM state encodings;
  - the 7-segment encoding function.
- Sub-module ps2_rx_frame holds the synchronisers, edge detect, FSM, parity check and timeout. It outputs scan_code, code_valid and frame_err.
- The top level holds the flag tracking, the entry register and the display multiplexer.

Test Plan:
- Reset held, then released; send 16 with correct odd parity (p=0). Expect code_valid for one cycle, scan_code=16, digit_count=1, digits_bcd[3:0]=1; at an index 0 expect seg=79.
- Send 1E, 26, 25, 2E (NUM_DIGITS=4). Expect digits_bcd=16'h2345, digit_count=4; the leading 1 is dropped.
- Send F0 then 16 (break). Expect code_valid twice and digits_bcd unchanged; a following 16 then shifts in a 1.
- Send 16 with the parity bit flipped. Expect frame_err pulse, no code_valid, scan_code holding its previous value. Separately, stop driving after 4 bits: expect frame_err after TIMEOUT_CYCLES, FSM back in IDLE, and the next full frame received correctly.
- Enter 7, 8, then 66. Expect digit_count=1, digits_bcd[3:0]=7. Then send 76: expect digit_count=0 and seg=7F on all digits.
- Assert reset mid-frame at bit 5. Expect all outputs at reset values; after release, a complete 70 frame (keypad 0) yields digit_count=1, digits_bcd[3:0]=0, seg=40.
